seq_borrow_select_subtractor: RTL and testbench
===============================================

Name: seq_borrow_select_subtractor

Overview:
- Multi-cycle unsigned subtractor: computes D = A - B and borrow-out, processing CHUNK bits per clock, LSB chunk first.
- Each chunk is computed for both borrow-in values (0 and 1), and the stored borrow selects the result. This is the borrow-select counterpart of the team's carry-select adder.
- Sits behind a valid/ready operand interface and a valid/ready result interface.
- Serves as the subtract path alongside the 32-bit adder in the datapath lab.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits processed per RUN cycle. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands A, B are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- out_valid  output  1  D and Bout are valid
- out_ready  input  1  consumer accepts the result
- D  output  WIDTH  difference A - B, modulo 2^WIDTH
- Bout  output  1  final borrow; 1 if and only if A < B (unsigned)

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, D=0, Bout=0, internal borrow=0, chunk index=0. Reset mid-RUN or mid-DONE aborts the operation and discards the result.
- States:
  - IDLE: in_ready=1. When in_valid=1 at a clock edge: latch A and B, borrow<=0, idx<=0, go to RUN.
  - RUN: in_ready=0. Each cycle:
    - sub0 = A_chunk - B_chunk; sub1 = A_chunk - B_chunk - 1, both CHUNK+1 bits wide.
    - Select by the stored borrow, write the result into D[idx*CHUNK +: CHUNK], and update borrow from the selected result's MSB.
    - idx increments. After chunk NCHUNK-1, go to DONE with Bout = final borrow.
  - DONE: out_valid=1, D and Bout held stable. When out_ready=1 at an edge: out_valid<=0, go to IDLE. D and Bout hold their last value until the next operation overwrites them.
- Latency: out_valid rises exactly NCHUNK clocks after the accepting edge (4 clocks at the defaults).
- Throughput: one operation per NCHUNK+2 clocks minimum; no overlap between operations.
- in_valid while not IDLE: ignored, and the operands are not sampled. Latched operands are immune to A/B changes during RUN.
- out_ready while not DONE: ignored. out_ready held high continuously: the result is visible for exactly one cycle.
- Partial-result visibility: lower D chunks update during RUN. Consumers must qualify D with out_valid.
- A == B gives D=0, Bout=0. A=0, B=max gives D=1, Bout=1.

Optional Feature:
- Macro: SUB_SIGNED_OVF_EN.
- Defined:
  - Adds output port Ovf (1 bit), valid with out_valid, reset value 0.
  - Ovf = (A[WIDTH-1] != B[WIDTH-1]) && (D[WIDTH-1] != A[WIDTH-1]), i.e. two's-complement overflow, computed in DONE from the latched operands.
- Undefined: no Ovf port and no related logic; all other behaviour is identical.

Decomposition:
- Shared package sub_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits
  - default WIDTH/CHUNK constants
  - function clog2 for sizing idx
- Sub-module borrow_select_chunk (combinational):
  - inputs: a, b (CHUNK each), bin
  - outputs: diff (CHUNK), bout
  - internally forms the two candidate differences and muxes on bin
  - instantiated once and time-multiplexed over the chunks

Test Plan:
- Reset mid-RUN: assert rst 2 clocks after accepting A=5, B=3 -> immediately in_ready=1, out_valid=0, D=0, Bout=0.
- Basic: A=5, B=3, out_ready=1 -> out_valid rises 4 clocks after the accept edge with D=0x00000002, Bout=0, high for 1 cycle.
- Full borrow ripple: A=0x00000000, B=0x00000001 -> D=0xFFFFFFFF, Bout=1. Borrow must propagate through all 4 chunks.
- Mixed vector: A=0xA0A0FFFF, B=0xA0BFFFE0 -> D=0xFFE1001F, Bout=1. Then A=0xDFFFE8CA, B=0xCFFFF8CA -> D=0x0FFFF000, Bout=0.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid rises, pulse in_valid meanwhile with new operands -> D and Bout stay stable, in_ready=0, new operands ignored. After out_ready=1: IDLE, then a new accept.
- With SUB_SIGNED_OVF_EN: A=0x80000000, B=0x00000001 -> D=0x7FFFFFFF, Bout=0, Ovf=1. A=5, B=3 -> Ovf=0.

Source files
------------

// File: rtl/sub_pkg.sv
// sub_pkg: shared types and constants for the sequential borrow-select subtractor.
//   state_t   : FSM encoding {IDLE, RUN, DONE}
//   SUB_WIDTH : default operand/result width
//   SUB_CHUNK : default bits processed per RUN cycle
//   clog2     : ceiling log2, used to size the chunk index
package sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int SUB_WIDTH = 32;
    localparam int SUB_CHUNK = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/borrow_select_chunk.sv
// borrow_select_chunk: combinational CHUNK-bit subtract slice with borrow select.
//   a, b : chunk operands (minuend, subtrahend)
//   bin  : borrow into this chunk
//   diff : chunk difference
//   bout : borrow out of this chunk
module borrow_select_chunk
#(
    parameter int CHUNK = 8
)
(
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] diff,
    output logic             bout
);

    logic [CHUNK:0] sub0;
    logic [CHUNK:0] sub1;

    // Both candidates are formed up front; the MSB of each is its borrow.
    assign sub0 = {1'b0, a} - {1'b0, b};
    assign sub1 = {1'b0, a} - {1'b0, b} - (CHUNK+1)'(1);

    assign {bout, diff} = bin ? sub1 : sub0;

endmodule

// File: rtl/seq_borrow_select_subtractor.sv
// seq_borrow_select_subtractor: multi-cycle unsigned D = A - B, CHUNK bits per clock, LSB first.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : operand handshake (in_ready only in IDLE)
//   A, B                 : minuend, subtrahend
//   out_valid, out_ready : result handshake (out_valid only in DONE)
//   D, Bout              : difference mod 2^WIDTH, borrow (A < B)
//   Ovf                  : signed overflow, present only with SUB_SIGNED_OVF_EN defined
module seq_borrow_select_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int CHUNK = SUB_CHUNK
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (clog2(NCHUNK) > 0) ? clog2(NCHUNK) : 1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic              borrow_q, borrow_d;
    logic              bout_q, bout_d;
    logic [IW-1:0]     idx_q, idx_d;

    logic [CHUNK-1:0]  chunk_diff;
    logic              chunk_bout;
    logic              last;

    // One slice, walked across the latched operands by idx_q.
    borrow_select_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_q[int'(idx_q)*CHUNK +: CHUNK]),
        .b    (b_q[int'(idx_q)*CHUNK +: CHUNK]),
        .bin  (borrow_q),
        .diff (chunk_diff),
        .bout (chunk_bout)
    );

    assign last = (idx_q == IW'(NCHUNK-1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = 1'b0;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                d_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_diff;
                borrow_d = chunk_bout;
                idx_d    = idx_q + 1'b1;
                if (last) begin
                    bout_d  = chunk_bout;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            idx_q    <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign D         = d_q;
    assign Bout      = bout_q;

`ifdef SUB_SIGNED_OVF_EN
    // Operands of differing sign overflow when the result sign departs from the minuend.
    assign Ovf = out_valid && (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_q[WIDTH-1] != a_q[WIDTH-1]);
`endif

endmodule

// File: tb/tb_seq_borrow_select_subtractor.sv
// tb_seq_borrow_select_subtractor: directed self-checking bench with a result scoreboard.
module tb_seq_borrow_select_subtractor;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
`ifdef SUB_SIGNED_OVF_EN
    logic             ovf;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    seq_borrow_select_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .Ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int bp);
        exp_t e;
        int   lat;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 1);
        out_ready = (bp == 0);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        @(posedge clk);
        e.d    = a - b;
        e.bout = (a < b);
        e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
        sb_q.push_back(e);
        #1;
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 20);
        check("latency", lat, NCHUNK);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("D", D, e.d);
            check("Bout", 32'(Bout), 32'(e.bout));
`ifdef SUB_SIGNED_OVF_EN
            check("Ovf", 32'(ovf), 32'(e.ovf));
`endif
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                check("bp_out_valid", 32'(out_valid), 1);
                check("bp_in_ready", 32'(in_ready), 0);
                check("bp_D", D, e.d);
                check("bp_Bout", 32'(Bout), 32'(e.bout));
                in_valid = ~in_valid;
                A = $urandom;
                B = $urandom;
            end
        end
        if (bp > 0) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("out_valid_drop", 32'(out_valid), 0);
        check("in_ready_back", 32'(in_ready), 1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_D", D, 0);
        check("rst_Bout", 32'(Bout), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Abort an operation two clocks into RUN.
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        A         = 32'd5;
        B         = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_in_ready", 32'(in_ready), 1);
        check("midrun_out_valid", 32'(out_valid), 0);
        check("midrun_D", D, 0);
        check("midrun_Bout", 32'(Bout), 0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;

        run_op(32'd5, 32'd3, 0);
        run_op(32'h00000000, 32'h00000001, 0);
        run_op(32'hA0A0FFFF, 32'hA0BFFFE0, 0);
        run_op(32'hDFFFE8CA, 32'hCFFFF8CA, 0);
        run_op(32'h12345678, 32'h12345678, 0);
        run_op(32'h00000000, 32'hFFFFFFFF, 6);
        run_op(32'h80000000, 32'h00000001, 0);
        run_op(32'd5, 32'd3, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
